// File: rtl/pixel_enhance_if.sv
// Pixel stream interface: one 8-bit greyscale pixel per valid/ready handshake.
// The producer side uses the master modport, the consumer side the slave modport.
interface pixel_enhance_if;
    logic       valid;
    logic       ready;
    logic [7:0] pixel;

    modport master (
        output valid,
        output pixel,
        input  ready
    );

    modport slave (
        input  valid,
        input  pixel,
        output ready
    );
endinterface

// File: rtl/pixel_enhance.sv
// pixel_enhance: streaming brightness adjust between the pixel source and bmp_write.
// Each accepted pixel gets a saturating add or subtract of a per-frame offset and
// leaves through a two-stage pipeline. The block counts delivered pixels and raises
// done once the whole frame has been handed downstream.
// Optional feature macro: PIX_THRESHOLD_EN makes stage 2 binarize the adjusted pixel
// against a per-frame threshold; without it stage 2 passes the pixel through.
module pixel_enhance #(
    parameter int TOTAL_PIXELS = 120000,
    parameter int COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         brightness,
    input  logic               bright_add,
    input  logic [7:0]         threshold,
    pixel_enhance_if.slave     in_bus,
    pixel_enhance_if.master    out_bus,
    output logic [COUNT_W-1:0] data_count,
    output logic               done
);

    localparam logic [COUNT_W-1:0] TOTAL_C = COUNT_W'(TOTAL_PIXELS);
    localparam logic [COUNT_W-1:0] LAST_C  = COUNT_W'(TOTAL_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]         bright_r;
    logic               add_r;
    logic [COUNT_W-1:0] in_cnt;

    logic               s1_valid;
    logic [7:0]         s1_pix;
    logic               out_valid_r;
    logic [7:0]         out_pixel_r;

    logic               advance;
    logic               accept;
    logic               deliver;
    logic               start_ok;
    logic               last_in;
    logic               last_out;

    logic [8:0]         sum9;
    logic [7:0]         adj;
    logic [7:0]         stage2;

`ifdef PIX_THRESHOLD_EN
    logic [7:0]         thr_r;
`else
    logic               unused_threshold;
    assign unused_threshold = ^threshold;
`endif

    // Both pipeline stages move together; they only hold while the output is stuck.
    assign advance  = out_bus.ready | ~out_valid_r;
    assign in_bus.ready = (state == RUN) & (in_cnt < TOTAL_C) & advance;
    assign accept   = in_bus.valid & in_bus.ready;
    assign deliver  = out_valid_r & out_bus.ready;
    assign start_ok = start & ((state == IDLE) | (state == DONE));
    assign last_in  = accept & (in_cnt == LAST_C);
    assign last_out = deliver & (data_count == LAST_C);

    assign out_bus.valid = out_valid_r;
    assign out_bus.pixel = out_pixel_r;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame sequencing: start opens a frame, the last accept closes the input side,
    // the last hand-off closes the frame. start is ignored mid-frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = RUN;
            RUN:     if (last_in)  state_next = DRAIN;
            DRAIN:   if (last_out) state_next = DONE;
            DONE:    if (start)    state_next = RUN;
            default:               state_next = IDLE;
        endcase
    end

    // Per-frame configuration, captured only when a start is honoured.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bright_r <= 8'd0;
            add_r    <= 1'b0;
`ifdef PIX_THRESHOLD_EN
            thr_r    <= 8'd0;
`endif
        end else if (start_ok) begin
            bright_r <= brightness;
            add_r    <= bright_add;
`ifdef PIX_THRESHOLD_EN
            thr_r    <= threshold;
`endif
        end
    end

    // Saturating brightness adjust on the incoming pixel (9-bit sum catches overflow).
    always_comb begin
        sum9 = {1'b0, in_bus.pixel} + {1'b0, bright_r};
        adj  = 8'd0;
        if (add_r) begin
            adj = sum9[8] ? 8'd255 : sum9[7:0];
        end else begin
            adj = (in_bus.pixel < bright_r) ? 8'd0 : (in_bus.pixel - bright_r);
        end
    end

    // Stage 2 transform: binarize when thresholding is built in, otherwise pass through.
    always_comb begin
`ifdef PIX_THRESHOLD_EN
        stage2 = (s1_pix >= thr_r) ? 8'd255 : 8'd0;
`else
        stage2 = s1_pix;
`endif
    end

    // Two-stage pixel pipeline; the output register holds steady during back-pressure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_pix      <= 8'd0;
            out_valid_r <= 1'b0;
            out_pixel_r <= 8'd0;
        end else if (advance) begin
            s1_valid    <= accept;
            out_valid_r <= s1_valid;
            if (accept) begin
                s1_pix <= adj;
            end
            if (s1_valid) begin
                out_pixel_r <= stage2;
            end
        end
    end

    // Input and delivered-pixel counters; both can step in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_cnt     <= '0;
            data_count <= '0;
        end else if (start_ok) begin
            in_cnt     <= '0;
            data_count <= '0;
        end else begin
            if (accept) begin
                in_cnt <= in_cnt + COUNT_W'(1);
            end
            if (deliver) begin
                data_count <= data_count + COUNT_W'(1);
            end
        end
    end

    // Frame-complete flag: set after the last hand-off, cleared by the next start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            done <= 1'b0;
        end else if (start_ok) begin
            done <= 1'b0;
        end else if ((state == DRAIN) && last_out) begin
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_enhance.sv
// Testbench for pixel_enhance with a four-pixel frame.
// A negedge process keeps a frame-level model (expected-pixel queue, counts, done)
// and checks the DUT every cycle; directed tests pin literal results.
module tb_pixel_enhance;

    localparam int TOTAL = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  brightness;
    logic        bright_add;
    logic [7:0]  threshold;
    logic [31:0] data_count;
    logic        done;

    pixel_enhance_if in_if();
    pixel_enhance_if out_if();

    pixel_enhance #(
        .TOTAL_PIXELS(TOTAL),
        .COUNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .brightness(brightness),
        .bright_add(bright_add),
        .threshold(threshold),
        .in_bus(in_if),
        .out_bus(out_if),
        .data_count(data_count),
        .done(done)
    );

    int tests = 0;
    int fails = 0;

    // Model state
    bit   m_live = 0;
    bit   m_running = 0;
    bit   m_done = 0;
    int   m_accepted = 0;
    int   m_delivered = 0;
    int   m_b = 0;
    bit   m_add = 0;
    int   m_thr = 0;
    int   exp_q[$];
    int   got[$];
    bit   prev_hold = 0;
    int   prev_pix = 0;
    int   cycle = 0;
    int   first_acc = -1;
    int   first_ov = -1;

    int   stim[0:3];

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter for latency measurement
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int model_pix(input int p, input int b, input bit add, input int thr);
        int r;
        r = add ? (p + b) : (p - b);
        if (r > 255) r = 255;
        if (r < 0)   r = 0;
`ifdef PIX_THRESHOLD_EN
        r = (r >= thr) ? 255 : 0;
`else
        if (thr < 0) r = 0;
`endif
        return r;
    endfunction

    // Frame-level model and per-cycle comparison
    always @(negedge clk) begin
        logic exp_ready;
        if (!reset) begin
            m_live      = 1;
            m_running   = 0;
            m_done      = 0;
            m_accepted  = 0;
            m_delivered = 0;
            exp_q.delete();
            prev_hold   = 0;
        end else if (m_live) begin
            check_output("data_count", data_count, m_delivered);
            check_output("done", done, m_done);
            exp_ready = m_running && (m_accepted < TOTAL) && (out_if.ready || !out_if.valid);
            check_output("in_ready", in_if.ready, exp_ready);
            if (!m_running) check_output("idle_out_valid", out_if.valid, 0);
            if (prev_hold) begin
                check_output("hold_valid", out_if.valid, 1);
                check_output("hold_pixel", out_if.pixel, prev_pix);
            end
            if (start && !m_running) begin
                m_running   = 1;
                m_done      = 0;
                m_accepted  = 0;
                m_delivered = 0;
                m_b         = brightness;
                m_add       = bright_add;
                m_thr       = threshold;
                exp_q.delete();
            end else if (m_running) begin
                if (in_if.valid && in_if.ready) begin
                    exp_q.push_back(model_pix(in_if.pixel, m_b, m_add, m_thr));
                    m_accepted++;
                    if (first_acc < 0) first_acc = cycle;
                end
                if (out_if.valid && first_ov < 0) first_ov = cycle;
                if (out_if.valid && out_if.ready) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_out", 1, 0);
                    end else begin
                        check_output("out_pixel", out_if.pixel, exp_q.pop_front());
                    end
                    got.push_back(int'(out_if.pixel));
                    m_delivered++;
                    if (m_delivered == TOTAL) begin
                        m_running = 0;
                        m_done    = 1;
                    end
                end
            end
            prev_hold = out_if.valid && !out_if.ready;
            prev_pix  = out_if.pixel;
        end
    end

    task automatic start_frame(input int b, input bit add, input int thr);
        got.delete();
        first_acc  = -1;
        first_ov   = -1;
        brightness = 8'(b);
        bright_add = add;
        threshold  = 8'(thr);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("start_done_clr", done, 0);
        check_output("start_cnt_clr", data_count, 0);
    endtask

    task automatic pulse_start(input int b);
        brightness = 8'(b);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic apply_stimulus(input int first, input int n);
        bit acc;
        int budget;
        for (int i = first; i < first + n; i++) begin
            in_if.valid = 1'b1;
            in_if.pixel = 8'(stim[i]);
            acc    = 0;
            budget = 100;
            while (!acc && budget > 0) begin
                @(negedge clk);
                acc = in_if.ready;
                @(posedge clk);
                #1;
                budget--;
            end
            if (!acc) check_output("accept_timeout", 0, 1);
        end
        in_if.valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 50;
        while (!done && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check_output("frame_done", done, 1);
        check_output("frame_count", data_count, TOTAL);
        check_output("no_drop", exp_q.size(), 0);
    endtask

    task automatic check_frame(input string name, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check_output({name, "_size"}, got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_output({name, "_pix"}, (i < got.size()) ? got[i] : -1, e[i]);
        end
    endtask

    task automatic check_reset_outputs();
        check_output("rst_done", done, 0);
        check_output("rst_count", data_count, 0);
        check_output("rst_out_valid", out_if.valid, 0);
        check_output("rst_out_pixel", out_if.pixel, 0);
        check_output("rst_in_ready", in_if.ready, 0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        brightness   = 8'd0;
        bright_add   = 1'b1;
        threshold    = 8'd0;
        in_if.valid  = 1'b0;
        in_if.pixel  = 8'd0;
        out_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

`ifdef PIX_THRESHOLD_EN
        // Binarize after a zero offset
        stim = '{127, 128, 200, 0};
        start_frame(0, 1'b1, 128);
        apply_stimulus(0, 4);
        wait_done();
        check_frame("thr_add", 0, 255, 255, 0);

        // Binarize after subtracting
        stim = '{149, 150, 200, 10};
        start_frame(100, 1'b0, 50);
        apply_stimulus(0, 4);
        wait_done();
        check_frame("thr_sub", 0, 255, 255, 0);
`else
        // Add with saturation, and two-cycle latency
        stim = '{0, 100, 250, 255};
        start_frame(10, 1'b1, 0);
        apply_stimulus(0, 4);
        wait_done();
        check_frame("add10", 10, 110, 255, 255);
        check_output("latency", first_ov - first_acc, 2);

        // Subtract with floor at zero
        stim = '{20, 50, 51, 200};
        start_frame(50, 1'b0, 0);
        apply_stimulus(0, 4);
        wait_done();
        check_frame("sub50", 0, 0, 1, 150);

        // Downstream stall for five cycles mid-frame
        stim = '{10, 20, 30, 40};
        start_frame(5, 1'b1, 0);
        fork
            apply_stimulus(0, 4);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_if.ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check_output("stall_in_ready", in_if.ready, 0);
                check_output("stall_out_valid", out_if.valid, 1);
                repeat (2) @(posedge clk);
                #1;
                out_if.ready = 1'b1;
            end
        join
        wait_done();
        check_frame("stall", 15, 25, 35, 45);

        // start mid-frame is ignored; start in DONE takes the new brightness
        stim = '{1, 2, 3, 4};
        start_frame(10, 1'b1, 0);
        apply_stimulus(0, 2);
        pulse_start(99);
        apply_stimulus(2, 2);
        wait_done();
        check_frame("ign_start", 11, 12, 13, 14);
        stim = '{0, 29, 30, 255};
        start_frame(30, 1'b0, 0);
        apply_stimulus(0, 4);
        wait_done();
        check_frame("restart", 0, 0, 0, 225);

        // Reset in the middle of a frame, then a clean frame
        stim = '{7, 8, 9, 10};
        start_frame(20, 1'b1, 0);
        apply_stimulus(0, 2);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        stim = '{254, 255, 7, 8};
        start_frame(1, 1'b1, 0);
        apply_stimulus(0, 4);
        wait_done();
        check_frame("post_reset", 255, 255, 8, 9);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
